// File: rtl/program_loader.sv
// Program loader: assembles a valid/ready byte stream (16-bit LE length, then LE words) into program memory writes.
// Latency: a word is written the cycle after its 4th byte is accepted; the core is released one cycle after the final write.
// Backpressure: byte_ready_o is low outside LEN_LO/LEN_HI/DATA and during every write cycle; the source holds unaccepted bytes.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   load_start_i          - start pulse (honoured in IDLE/DONE/ERROR)
//   byte_i/_valid_i/_ready_o - incoming byte stream handshake
//   mem_write_o/_address_o/_data_o - program memory write port
//   cpu_reset_o, done_o, error_o, word_count_o - core control and status
module program_loader #(
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        mem_write_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_reset_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] word_count_o
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    logic [1:0]  lane;
    logic [23:0] assembly;   // lanes 0..2; lane 3 is taken straight from byte_i
    logic [15:0] length;

    logic        byte_accept;
    logic [15:0] length_full;
    logic        length_bad;
    logic [15:0] count_next;

    assign byte_accept = byte_valid_i && byte_ready_o;
    assign length_full = {byte_i, length[7:0]};
    assign length_bad  = (length_full == 16'd0) ||
                         ({16'd0, length_full} > 32'(MEMORY_DEPTH));
    assign count_next  = word_count_o + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            byte_ready_o  <= 1'b0;
            mem_write_o   <= 1'b0;
            mem_address_o <= BASE_ADDRESS;
            mem_data_o    <= 32'd0;
            cpu_reset_o   <= 1'b1;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
            word_count_o  <= 16'd0;
            lane          <= 2'd0;
            assembly      <= 24'd0;
            length        <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (load_start_i) begin
                        state        <= LEN_LO;
                        byte_ready_o <= 1'b1;
                        cpu_reset_o  <= 1'b1;
                        done_o       <= 1'b0;
                        error_o      <= 1'b0;
                        word_count_o <= 16'd0;
                        lane         <= 2'd0;
                        length       <= 16'd0;
                    end
                end

                LEN_LO: begin
                    if (byte_accept) begin
                        length[7:0] <= byte_i;
                        state       <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (byte_accept) begin
                        length[15:8] <= byte_i;
                        if (length_bad) begin
                            state        <= ERROR;
                            error_o      <= 1'b1;
                            byte_ready_o <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (mem_write_o) begin
                        // Write cycle: no byte can be accepted (ready was cleared with the strobe).
                        mem_write_o  <= 1'b0;
                        word_count_o <= count_next;
                        if (count_next == length) begin
                            state        <= DONE;
                            done_o       <= 1'b1;
                            cpu_reset_o  <= 1'b0;
                            byte_ready_o <= 1'b0;
                        end else begin
                            byte_ready_o <= 1'b1;
                        end
                    end else if (byte_accept) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: assembly[7:0]   <= byte_i;
                            2'd1: assembly[15:8]  <= byte_i;
                            2'd2: assembly[23:16] <= byte_i;
                            default: begin
                                mem_write_o   <= 1'b1;
                                byte_ready_o  <= 1'b0;
                                mem_data_o    <= {byte_i, assembly};
                                mem_address_o <= BASE_ADDRESS + {14'd0, word_count_o, 2'b00};
                            end
                        endcase
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: byte-stream loads, length errors, mid-load reset and reload from DONE.
// Latency: n/a (testbench).
// Backpressure: source holds each byte until byte_ready_o is seen at a rising edge.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic        cpu_reset_o;
    logic        done_o;
    logic        error_o;
    logic [15:0] word_count_o;

    int checks = 0;
    int errors = 0;
    int ready_during_write = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    program_loader dut (
        .clk           (clk),
        .reset         (reset),
        .load_start_i  (load_start_i),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_ready_o  (byte_ready_o),
        .mem_write_o   (mem_write_o),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .cpu_reset_o   (cpu_reset_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .word_count_o  (word_count_o)
    );

    always #5 clk = ~clk;

    // Memory-side recorder.
    always @(negedge clk) begin
        if (mem_write_o) begin
            wr_addr.push_back(mem_address_o);
            wr_data.push_back(mem_data_o);
            if (byte_ready_o) ready_during_write++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start_i = 1'b1;
        step();
        load_start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic got;
        byte_valid_i = 1'b0;
        repeat (gap) step();
        byte_i       = b;
        byte_valid_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            got = byte_ready_o;
            step();
        end
        byte_valid_i = 1'b0;
        if (!got) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * i);
            send_byte(tmp[7:0], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 32'(wr_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
            check({tag, "_addr"}, wr_addr[i], exp_addr[i]);
            check({tag, "_data"}, wr_data[i], exp_data[i]);
        end
        wr_addr.delete(); wr_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    initial begin
        reset        = 1'b1;
        load_start_i = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        step(); step();
        reset = 1'b0;

        // Reset state and idle.
        check("rst_addr", mem_address_o, 32'h0040_0000);
        check("rst_data", mem_data_o, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("idle_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
            check("idle_ready", {31'd0, byte_ready_o}, 32'd0);
            check("idle_write", {31'd0, mem_write_o}, 32'd0);
            check("idle_wc", {16'd0, word_count_o}, 32'd0);
            check("idle_done", {31'd0, done_o}, 32'd0);
            check("idle_error", {31'd0, error_o}, 32'd0);
            step();
        end

        // Two-word load, back-to-back bytes.
        pulse_start();
        check("start_ready", {31'd0, byte_ready_o}, 32'd1);
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_word(32'h1234_5678, 0);
        send_word(32'hDEAD_BEEF, 0);
        // Last byte just accepted: write cycle, core still held.
        check("last_write", {31'd0, mem_write_o}, 32'd1);
        check("last_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        check("last_done", {31'd0, done_o}, 32'd0);
        step();
        check("done_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);
        check("done_flag", {31'd0, done_o}, 32'd1);
        check("done_wc", {16'd0, word_count_o}, 32'd2);
        check("done_ready", {31'd0, byte_ready_o}, 32'd0);
        exp_addr.push_back(32'h0040_0000); exp_data.push_back(32'h1234_5678);
        exp_addr.push_back(32'h0040_0004); exp_data.push_back(32'hDEAD_BEEF);
        check_writes("load2");

        // Reload from DONE.
        pulse_start();
        check("reload_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        check("reload_done", {31'd0, done_o}, 32'd0);
        check("reload_wc", {16'd0, word_count_o}, 32'd0);
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_word(32'h2008_0005, 0);
        step();
        check("reload_done_flag", {31'd0, done_o}, 32'd1);
        check("reload_wc_end", {16'd0, word_count_o}, 32'd1);
        exp_addr.push_back(32'h0040_0000); exp_data.push_back(32'h2008_0005);
        check_writes("reload");

        // Zero length.
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("len0_error", {31'd0, error_o}, 32'd1);
        check("len0_ready", {31'd0, byte_ready_o}, 32'd0);
        check("len0_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        step(); step();
        check_writes("len0");

        // Length 33 > depth.
        pulse_start();
        check("err_clear", {31'd0, error_o}, 32'd0);
        send_byte(8'h21, 0); send_byte(8'h00, 0);
        check("len33_error", {31'd0, error_o}, 32'd1);
        check("len33_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        step(); step();
        check_writes("len33");

        // Three-word image with random valid gaps.
        pulse_start();
        send_byte(8'h03, 2); send_byte(8'h00, 3);
        send_word(32'h1234_5678, 3);
        send_word(32'hDEAD_BEEF, 3);
        send_word(32'hCAFE_F00D, 3);
        step();
        check("gap_done", {31'd0, done_o}, 32'd1);
        check("gap_wc", {16'd0, word_count_o}, 32'd3);
        exp_addr.push_back(32'h0040_0000); exp_data.push_back(32'h1234_5678);
        exp_addr.push_back(32'h0040_0004); exp_data.push_back(32'hDEAD_BEEF);
        exp_addr.push_back(32'h0040_0008); exp_data.push_back(32'hCAFE_F00D);
        check_writes("gap");
        check("ready_in_write", 32'(ready_during_write), 32'd0);

        // Reset after 5 bytes of a 2-word load; load_start_i together with reset.
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        reset = 1'b1;
        load_start_i = 1'b1;
        step();
        reset = 1'b0;
        load_start_i = 1'b0;
        check("mid_rst_ready", {31'd0, byte_ready_o}, 32'd0);
        check("mid_rst_wc", {16'd0, word_count_o}, 32'd0);
        check("mid_rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        check("mid_rst_addr", mem_address_o, 32'h0040_0000);
        step(); step();
        check("mid_rst_idle_ready", {31'd0, byte_ready_o}, 32'd0);
        check_writes("mid_rst");

        // Full load after the aborted one.
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_word(32'hA5A5_0F0F, 1);
        send_word(32'h0000_00FF, 1);
        step();
        check("after_rst_done", {31'd0, done_o}, 32'd1);
        check("after_rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);
        exp_addr.push_back(32'h0040_0000); exp_data.push_back(32'hA5A5_0F0F);
        exp_addr.push_back(32'h0040_0004); exp_data.push_back(32'h0000_00FF);
        check_writes("after_rst");
        check("ready_in_write_final", 32'(ready_during_write), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Upstream neighbour of the single-cycle MIPS core. It receives a program as a byte stream over a valid/ready handshake and assembles the bytes into 32-bit little-endian instruction words. It writes those words into the program memory at consecutive word addresses. While loading it holds the processor in reset, and releases it once the full image has been written.

Parameters:
MEMORY_DEPTH, 32, program memory capacity in 32-bit words; the largest legal image length.
BASE_ADDRESS, 32'h0040_0000, byte address written for word 0; must be word aligned.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
load_start_i  input  1  single-cycle pulse that starts a load; honoured only in IDLE, DONE and ERROR.
byte_i  input  8  incoming stream byte.
byte_valid_i  input  1  byte_i holds a valid byte.
byte_ready_o  output  1  loader can accept a byte this cycle.
mem_write_o  output  1  one-cycle write strobe to the program memory.
mem_address_o  output  32  byte address of the word being written.
mem_data_o  output  32  instruction word being written.
cpu_reset_o  output  1  reset to the MIPS core; high keeps the core held.
done_o  output  1  image loaded successfully; core running.
error_o  output  1  illegal image length received.
word_count_o  output  16  number of words written in the current load.

Behaviour:
- Reset values:
  - state = IDLE; byte_ready_o = 0; mem_write_o = 0.
  - mem_address_o = BASE_ADDRESS; mem_data_o = 0.
  - cpu_reset_o = 1; done_o = 0; error_o = 0; word_count_o = 0.
  - Byte-lane counter = 0; length register = 0.
- Handshake: a byte is accepted when byte_valid_i and byte_ready_o are both 1 at the rising edge.
  - Bytes presented while byte_ready_o = 0 are not consumed; the source holds them.
- byte_ready_o = 1 only in LEN_LO, LEN_HI and DATA.
  - Forced to 0 in any cycle where mem_write_o = 1.
- States:
  - IDLE: cpu_reset_o = 1. On load_start_i: clear counters, error_o and done_o; go to LEN_LO.
  - LEN_LO: accept one byte into length[7:0]; go to LEN_HI.
  - LEN_HI: accept one byte into length[15:8].
    - If the length {byte_i, length[7:0]} is 0 or greater than MEMORY_DEPTH: go to ERROR.
    - Otherwise go to DATA.
  - DATA: each accepted byte fills lane 0..3 of the assembly register. The first byte goes to bits 7:0, the fourth to bits 31:24.
    - On acceptance of the 4th byte at edge k, in cycle k+1:
      - mem_write_o = 1.
      - mem_data_o = the assembled word.
      - mem_address_o = BASE_ADDRESS + 4*word_count_o, using the pre-increment value.
    - word_count_o increments at edge k+1.
    - The lane counter wraps from 3 to 0.
    - If the word just written is word number length, the state moves to DONE at edge k+1.
  - DONE: cpu_reset_o = 0; done_o = 1. The first cycle with cpu_reset_o = 0 is k+2.
    - load_start_i returns to LEN_LO. cpu_reset_o = 1 and done_o = 0 from the next cycle; word_count_o clears.
  - ERROR: error_o = 1; cpu_reset_o = 1; no memory writes.
    - load_start_i behaves as in IDLE and clears error_o.
- load_start_i in LEN_LO, LEN_HI or DATA is ignored.
- mem_address_o and mem_data_o hold their last values when mem_write_o = 0.
- Address arithmetic is 32-bit unsigned. An image length of at most MEMORY_DEPTH guarantees no wrap beyond the program memory range.
- Reset asserted in any state, including mid-word: return to the reset values at the next edge.
  - The partial word is discarded; no write strobe is issued.
  - cpu_reset_o = 1 in the following cycle.
- Simultaneous reset and load_start_i: reset wins; state = IDLE.
- Every output is registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then idle for 5 cycles -> cpu_reset_o = 1, byte_ready_o = 0, mem_write_o = 0, word_count_o = 0, done_o = 0, error_o = 0 throughout.
- load_start_i, then bytes 02 00 78 56 34 12 EF BE AD DE sent back-to-back -> two write pulses:
  - first: 0x12345678 @ 0x00400000;
  - second: 0xDEADBEEF @ 0x00400004;
  - word_count_o = 2, done_o = 1, and cpu_reset_o falls 2 cycles after the last byte is accepted.
- Length 00 00 -> error_o = 1 with no write; after load_start_i, length 21 00 (33 > 32) -> error_o = 1; cpu_reset_o stays 1 in both cases.
- Random byte_valid_i gaps during a 3-word image -> identical written words and addresses as the gap-free case; byte_ready_o = 0 during each write cycle; no byte lost or duplicated.
- Reset asserted after 5 bytes of a 2-word load -> no write strobe, state IDLE, word_count_o = 0; a subsequent full load succeeds.
- From DONE, pulse load_start_i -> cpu_reset_o = 1 and done_o = 0 in the next cycle; a reload of 1 word 0x20080005 is written to 0x00400000.
